// File: rtl/pipe_credit_sink_pkg.sv
// Shared constants and helpers for the pipe_credit_sink block.
package pipe_credit_sink_pkg;

    localparam int DEFAULT_DEPTH = 4;

    // Wrapping increment so that non-power-of-2 depths cycle 0..depth-1.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_credit_sink_if.sv
// Launch-credit, pipeline-result and ready/valid output signals of pipe_credit_sink.
import pipe_credit_sink_pkg::*;

interface pipe_credit_sink_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic             issue_ready;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    credits;

    modport master (
        output issue_valid, pipe_valid, pipe_data, out_ready,
        input  issue_ready, out_valid, out_data, credits
    );

    modport slave (
        input  issue_valid, pipe_valid, pipe_data, out_ready,
        output issue_ready, out_valid, out_data, credits
    );

endinterface

// File: rtl/pipe_credit_sink_fifo.sv
// Circular-buffer FIFO for pipe_credit_sink; the push side has no ready.
// PIPE_CREDIT_SINK_OVF_EN exposes full/count for overflow detection and checks.
import pipe_credit_sink_pkg::*;

module pipe_credit_sink_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
`ifdef PIPE_CREDIT_SINK_OVF_EN
    ,
    output logic             full,
    output logic [CW-1:0]    count
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);
    assign do_pop   = pop && !is_empty;
    // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
    assign do_push  = push && (!is_full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (do_pop)
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rd_data = is_empty ? '0 : mem[rd_ptr];
    assign empty   = is_empty;

`ifdef PIPE_CREDIT_SINK_OVF_EN
    assign full  = is_full;
    assign count = cnt;
`endif

endmodule

// File: rtl/pipe_credit_sink.sv
// Credit-based sink for a valid-only pipeline: launches are gated by FIFO-slot credits.
// Define PIPE_CREDIT_SINK_OVF_EN to add the sticky overflow port and sanity assertions.
import pipe_credit_sink_pkg::*;

module pipe_credit_sink #(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    pipe_credit_sink_if.slave bus
`ifdef PIPE_CREDIT_SINK_OVF_EN
    ,
    output logic              overflow
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_next;
    logic          issue_ready_q;
    logic          issue;
    logic          pop;
    logic          empty;
`ifdef PIPE_CREDIT_SINK_OVF_EN
    logic          full;
    logic [CW-1:0] count;
`endif

    assign issue = bus.issue_valid && issue_ready_q;
    assign pop   = !empty && bus.out_ready;

    // A credit comes back only when its beat leaves the FIFO, never on push.
    always_comb begin
        credits_next = credits_q;
        if (issue && !pop)
            credits_next = credits_q - 1'b1;
        else if (pop && !issue)
            credits_next = credits_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q     <= CW'(DEPTH);
            issue_ready_q <= 1'b1;
        end else begin
            credits_q     <= credits_next;
            issue_ready_q <= (credits_next != '0);
        end
    end

    pipe_credit_sink_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.pipe_valid),
        .pop     (pop),
        .wr_data (bus.pipe_data),
        .rd_data (bus.out_data),
        .empty   (empty)
`ifdef PIPE_CREDIT_SINK_OVF_EN
        ,
        .full    (full),
        .count   (count)
`endif
    );

    assign bus.issue_ready = issue_ready_q;
    assign bus.credits     = credits_q;
    assign bus.out_valid   = !empty;

`ifdef PIPE_CREDIT_SINK_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (bus.pipe_valid && full && !pop)
            overflow <= 1'b1;
    end

    assert property (@(posedge clk) disable iff (rst) credits_q <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        ({1'b0, credits_q} + {1'b0, count}) <= (CW + 1)'(DEPTH));
`else
    // Without the option, a beat pushed into a full FIFO is dropped silently.
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Self-checking bench for pipe_credit_sink: DEPTH=4 and DEPTH=3 instances, latency-1 pipeline model.
`timescale 1ns/1ps
module tb_pipe_credit_sink;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sel  = 1'b0;
    logic        iv   = 1'b0;
    logic        ordy = 1'b0;
    logic        pv   = 1'b0;
    logic [31:0] pd   = '0;

    always #5 clk = ~clk;

    pipe_credit_sink_if #(.WIDTH(32), .DEPTH(4)) b4 ();
    pipe_credit_sink_if #(.WIDTH(32), .DEPTH(3)) b3 ();

    // Only the selected instance sees traffic; the other idles.
    assign b4.issue_valid = iv & ~sel;
    assign b4.pipe_valid  = pv & ~sel;
    assign b4.pipe_data   = pd;
    assign b4.out_ready   = ordy & ~sel;
    assign b3.issue_valid = iv & sel;
    assign b3.pipe_valid  = pv & sel;
    assign b3.pipe_data   = pd;
    assign b3.out_ready   = ordy & sel;

`ifdef PIPE_CREDIT_SINK_OVF_EN
    logic ovf4, ovf3;
    pipe_credit_sink #(.WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4), .overflow(ovf4));
    pipe_credit_sink #(.WIDTH(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3), .overflow(ovf3));
`else
    pipe_credit_sink #(.WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    pipe_credit_sink #(.WIDTH(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
`endif

    logic        cur_ir, cur_ov;
    logic [31:0] cur_od;
    int          cur_cr;
    always_comb begin
        cur_ir = sel ? b3.issue_ready : b4.issue_ready;
        cur_ov = sel ? b3.out_valid   : b4.out_valid;
        cur_od = sel ? b3.out_data    : b4.out_data;
        cur_cr = sel ? int'(b3.credits) : int'(b4.credits);
    end

    // Reference model: FIFO contents as a queue, credits as DEPTH minus unreturned launches.
    int          mdepth   = 4;
    int          mcred    = 4;
    int          inflight = 0;
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    bit          m_ovf    = 1'b0;
    bit          pend     = 1'b0;
    logic [31:0] pend_d   = '0;
    logic [31:0] next_launch = '0;
    bit          inv_chk  = 1'b0;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          iv;
        bit          ordy;
        bit          ir;
        int          cr;
        bit          ov;
        logic [31:0] od;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        check("issue_ready", 32'(cur_ir), 32'(mcred != 0));
        check("credits", 32'(cur_cr), 32'(mcred));
        check("out_valid", 32'(cur_ov), 32'(mq.size() != 0));
        check("out_data", cur_od, head);
        if (inv_chk)
            check("invariant", 32'(cur_cr + mq.size() + inflight), 32'(mdepth));
`ifdef PIPE_CREDIT_SINK_OVF_EN
        check("overflow", 32'(sel ? ovf3 : ovf4), 32'(m_ovf));
`endif
    endtask

    // Called at a negedge: drive one cycle, check, advance model, move to next negedge.
    task automatic applyStimulus(input bit i_v, input bit o_r, input bit force_en, input logic [31:0] force_d);
        bit do_issue, do_pop;
        iv   = i_v;
        ordy = o_r;
        if (force_en) begin
            pv = 1'b1;
            pd = force_d;
        end else begin
            pv = pend;
            pd = pend_d;
        end
        #1;
        checkOutput();
        do_issue = i_v && (mcred != 0);
        do_pop   = o_r && (mq.size() != 0);
        if (do_pop)
            popped.push_back(mq.pop_front());
        if (pv) begin
            if (mq.size() < mdepth)
                mq.push_back(pd);
            else
                m_ovf = 1'b1;
            if (!force_en)
                inflight--;
        end
        mcred = mcred - int'(do_issue) + int'(do_pop);
        pend  = do_issue;
        if (do_issue) begin
            pend_d = next_launch;
            next_launch++;
            inflight++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        iv = 1'b0; pv = 1'b0; ordy = 1'b0;
        mq.delete();
        popped.delete();
        mcred = mdepth; inflight = 0; pend = 1'b0; m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fillFull(input logic [31:0] base);
        next_launch = base;
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        popped.delete();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2, 1'b1, 32'h100};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 32'h100};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h100};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h100};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 32'h100};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 32'h101};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 32'h102};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 32'h103};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4, 1'b0, 32'h0};

        @(negedge clk);
        sel = 1'b0; mdepth = 4;
        doReset();

        // Stall: credits run out after exactly four launches, then return one per pop.
        next_launch = 32'h100;
        for (int i = 0; i < 11; i++) begin
            check("stall_ready", 32'(cur_ir), 32'(tbl[i].ir));
            check("stall_credits", 32'(cur_cr), 32'(tbl[i].cr));
            check("stall_valid", 32'(cur_ov), 32'(tbl[i].ov));
            check("stall_data", cur_od, tbl[i].od);
            applyStimulus(tbl[i].iv, tbl[i].ordy, 1'b0, '0);
        end

        // Streaming: 16 back-to-back launches, never throttled.
        doReset();
        next_launch = 32'h0;
        for (int i = 0; i < 16; i++) begin
            check("stream_ready", 32'(cur_ir), 32'h1);
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
        end
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        check("stream_count", 32'(popped.size()), 32'd16);
        for (int i = 0; i < 16 && i < popped.size(); i++)
            check("stream_order", popped[i], 32'(i));

`ifndef PIPE_CREDIT_SINK_OVF_EN
        // Push and pop in the same cycle while full: new beat wraps into the freed slot.
        doReset();
        fillFull(32'h200);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h55);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        check("full_pp_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("full_pp_order", popped[i], (i == 4) ? 32'h55 : 32'h200 + 32'(i));
`endif

        // Protocol violation: push while full and not popping is dropped.
        doReset();
        fillFull(32'h300);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hEE);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        check("drop_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            check("drop_order", popped[i], 32'h300 + 32'(i));
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Random traffic, then an asynchronous reset in the middle of it.
        doReset();
        inv_chk = 1'b1;
        next_launch = 32'h1000;
        repeat (300) applyStimulus(1'($urandom), 1'($urandom), 1'b0, '0);
        rst = 1'b1;
        #2;
        check("reset_credits", 32'(cur_cr), 32'd4);
        check("reset_ready", 32'(cur_ir), 32'h1);
        check("reset_valid", 32'(cur_ov), 32'h0);
        check("reset_data", cur_od, 32'h0);
        @(negedge clk);
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0);

        // DEPTH=3: wrap at a non-power-of-2 boundary with random downstream stalls.
        sel = 1'b1; mdepth = 3;
        doReset();
        next_launch = 32'h400;
        for (int c = 0; c < 400 && popped.size() < 10; c++)
            applyStimulus((next_launch - 32'h400) < 32'd10, 1'($urandom_range(0, 1)), 1'b0, '0);
        check("d3_count", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check("d3_order", popped[i], 32'h400 + 32'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
